// File: rtl/lca_wide_add_seq_if.sv
// Operand/result handshake bundle for lca_wide_add_seq.
// Define LCA_WIDE_ADD_SEQ_SUB_EN to add the sub control signal.
interface lca_wide_add_seq_if #(
  parameter int SLICE_W = 64,
  parameter int BEATS   = 4
);
  localparam int W = SLICE_W * BEATS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef LCA_WIDE_ADD_SEQ_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
`ifdef LCA_WIDE_ADD_SEQ_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
`ifdef LCA_WIDE_ADD_SEQ_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout
  );
endinterface

// File: rtl/lca_wide_add_seq.sv
// Wide adder that reuses one lookahead-carry slice over BEATS cycles.
// Define LCA_WIDE_ADD_SEQ_SUB_EN to enable subtract (sub input).
module lca_wide_add_seq #(
  parameter int SLICE_W = 64,
  parameter int BEATS   = 4
) (
  input  logic                clk,
  input  logic                rst,
  lca_wide_add_seq_if.slave   bus
);
  localparam int W  = SLICE_W * BEATS;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NG = SLICE_W / 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_sum;
  logic           r_carry;
  logic           r_cout;
  logic [BW-1:0]  r_beat;
`ifdef LCA_WIDE_ADD_SEQ_SUB_EN
  logic           r_sub;
`endif

  logic           w_accept;
  logic           w_last;
  logic           w_cin0;
  logic [SLICE_W-1:0] w_sa;
  logic [SLICE_W-1:0] w_sb;
  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_c;
  logic [NG:0]        w_gc;
  logic [SLICE_W-1:0] w_ss;
  logic               w_sc;

  // 4-bit lookahead group: returns {group carry-out, carries into bits 3..0}
  function automatic logic [4:0] grp(
    input logic [3:0] g,
    input logic [3:0] p,
    input logic       c
  );
    logic c1, c2, c3, co;
    c1 = g[0] | (p[0] & c);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
       | (p[2] & p[1] & p[0] & c);
    co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]) | (&p & c);
    return {co, c3, c2, c1, c};
  endfunction

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_last   = (r_beat == BW'(BEATS - 1));

  assign bus.in_ready  = (r_state == IDLE) && !rst;
  assign bus.out_valid = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;

  assign w_sa = r_a[int'(r_beat)*SLICE_W +: SLICE_W];
`ifdef LCA_WIDE_ADD_SEQ_SUB_EN
  assign w_sb   = r_b[int'(r_beat)*SLICE_W +: SLICE_W]
                ^ {SLICE_W{r_sub}};
  assign w_cin0 = bus.cin ^ bus.sub;
`else
  assign w_sb   = r_b[int'(r_beat)*SLICE_W +: SLICE_W];
  assign w_cin0 = bus.cin;
`endif

  // Slice adder: lookahead inside 4-bit groups, group carries chained
  always_comb begin
    w_g     = w_sa & w_sb;
    w_p     = w_sa ^ w_sb;
    w_c     = '0;
    w_gc    = '0;
    w_gc[0] = r_carry;
    for (int k = 0; k < NG; k++) begin
      {w_gc[k+1], w_c[4*k +: 4]} =
        grp(w_g[4*k +: 4], w_p[4*k +: 4], w_gc[k]);
    end
    w_ss = w_p ^ w_c;
    w_sc = w_gc[NG];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: one accept, BEATS slice cycles, hold until consumed
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)      w_next = RUN;
      RUN:     if (w_last)        w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  // Operand capture and per-beat slice accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_beat  <= '0;
`ifdef LCA_WIDE_ADD_SEQ_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= w_cin0;
      r_beat  <= '0;
`ifdef LCA_WIDE_ADD_SEQ_SUB_EN
      r_sub   <= bus.sub;
`endif
    end else if (r_state == RUN) begin
      r_sum[int'(r_beat)*SLICE_W +: SLICE_W] <= w_ss;
      r_carry <= w_sc;
      if (w_last) r_cout <= w_sc;
      else        r_beat <= r_beat + 1'b1;
    end
  end
endmodule

// File: tb/tb_lca_wide_add_seq.sv
// Self-checking bench for lca_wide_add_seq (default 64x4).
// Covers LCA_WIDE_ADD_SEQ_SUB_EN vectors when that macro is defined.
module tb_lca_wide_add_seq;
  localparam int SLICE_W = 64;
  localparam int BEATS   = 4;
  localparam int W       = SLICE_W * BEATS;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic cur_sub = 1'b0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] res_q[$];
  int           acc_q[$];

  lca_wide_add_seq_if #(.SLICE_W(SLICE_W), .BEATS(BEATS)) bus ();

  lca_wide_add_seq #(.SLICE_W(SLICE_W), .BEATS(BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic cin,
    input logic sub
  );
    logic [W-1:0] bb;
    bb = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin ^ sub};
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [W:0] act,
                       input logic [W:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop on result handshake
  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.a, bus.b, bus.cin, cur_sub));
      acc_q.push_back(cyc);
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got %h expected none",
                 {bus.cout, bus.sum});
      end else begin
        check("sb_result", {bus.cout, bus.sum}, exp_q.pop_front());
      end
      res_q.push_back(bus.sum);
    end
  end

  task automatic run_op(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    input  int           hold,
    output logic [W-1:0] s,
    output logic         co,
    output int           lat
  );
    int n;
    s   = '0;
    co  = 1'b0;
    lat = 0;
    cur_sub = sub;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
`ifdef LCA_WIDE_ADD_SEQ_SUB_EN
    bus.sub = sub;
`endif
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    bus.cin = ~cin;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!bus.out_valid) begin
      check("result_timeout", 0, 1);
      return;
    end
    s  = bus.sum;
    co = bus.cout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", bus.out_valid, 1);
      check("bp_hold", {bus.cout, bus.sum}, {co, s});
      check("bp_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("post_valid", bus.out_valid, 0);
    check("post_ready", bus.in_ready, 1);
  endtask

  vec_t         tbl[6];
  logic [W-1:0] s;
  logic [W-1:0] t;
  logic         co;
  int           lat;
  int           n;
  int           seen;

  initial begin
    tbl[0] = '{a: W'(1), b: '1, cin: 1'b0, s: '0, co: 1'b1};
    tbl[1] = '{a: '0, b: W'(1), cin: 1'b0, s: '0, co: 1'b0};
    tbl[1].a[63:0] = '1;
    tbl[1].s[64]   = 1'b1;
    tbl[2] = '{a: '1, b: '1, cin: 1'b1, s: '1, co: 1'b1};
    tbl[3] = '{a: W'(3), b: W'(4), cin: 1'b0, s: W'(7), co: 1'b0};
    tbl[4] = '{a: '0, b: '0, cin: 1'b1, s: W'(1), co: 1'b0};
    tbl[5] = '{a: {4{64'h8000_0000_0000_0000}},
               b: {4{64'h8000_0000_0000_0000}}, cin: 1'b0,
               s: {64'h1, 64'h1, 64'h1, 64'h0}, co: 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a   = '0;
    bus.b   = '0;
    bus.cin = 1'b0;
`ifdef LCA_WIDE_ADD_SEQ_SUB_EN
    bus.sub = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum_cout", {bus.cout, bus.sum}, '0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, 0, s, co, lat);
      check($sformatf("vec%0d", i), {co, s}, {tbl[i].co, tbl[i].s});
      if (i == 0) check("latency", lat, BEATS);
    end

    // Backpressure: result held for 10 cycles
    run_op(rnd(), rnd(), 1'b1, 1'b0, 10, s, co, lat);

    // Random operands checked by the scoreboard
    for (int i = 0; i < 4; i++)
      run_op(rnd(), rnd(), 1'($urandom), 1'b0, 0, s, co, lat);

    // in_valid held, out_ready tied high: two back-to-back operations
    res_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    cur_sub = 1'b0;
    bus.a = W'(3);
    bus.b = W'(4);
    bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    n = 0;
    while (acc_q.size() < 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.a = W'(10);
    bus.b = W'(20);
    n = 0;
    while (acc_q.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (res_q.size() < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    bus.out_ready = 1'b0;
    check("b2b_count", res_q.size(), 2);
    if (res_q.size() >= 2) begin
      check("b2b_first", res_q[0], W'(7));
      check("b2b_second", res_q[1], W'(30));
    end
    if (acc_q.size() >= 2)
      check("b2b_spacing", acc_q[1] - acc_q[0], BEATS + 2);

    // Reset at beat 2 aborts the operation
    t = rnd();
    bus.a = t;
    bus.b = t;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("abort_valid", bus.out_valid, 0);
    check("abort_sum_cout", {bus.cout, bus.sum}, '0);
    check("abort_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_idle_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    bus.out_ready = 1'b0;
    check("abort_no_result", seen, 0);

`ifdef LCA_WIDE_ADD_SEQ_SUB_EN
    t = '1;
    t[0] = 1'b0;
    run_op(W'(5), W'(7), 1'b0, 1'b1, 0, s, co, lat);
    check("sub_5_7", {co, s}, {1'b0, t});
    run_op(W'(7), W'(5), 1'b0, 1'b1, 0, s, co, lat);
    check("sub_7_5", {co, s}, {1'b1, W'(2)});
`endif

    repeat (2) @(posedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lca_wide_add_seq.md
# lca_wide_add_seq

Multi-cycle sequencer that adds two wide operands (SLICE_W*BEATS bits) by time-multiplexing one SLICE_W-bit lookahead carry adder slice over BEATS clock cycles. Carry is held in a register between beats. Operands enter and results leave through valid/ready handshakes. The block sits between a requester and the narrow adder datapath, trading latency for area on wide additions.

## Interface

Parameters:
- SLICE_W, 64, width of the internal lookahead carry adder slice; must be a multiple of 4.
- BEATS, 4, number of slices per operand; must be ≥1. Total width W = SLICE_W*BEATS.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A, sampled on accept.
- b  input  W  operand B, sampled on accept.
- cin  input  1  carry-in, sampled on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  registered result.
- cout  output  1  registered carry-out of the top slice.

## Operation

- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture a, b, cin into operand registers, set carry_reg=cin, beat=0, go RUN.
- RUN, one beat per cycle:
  - Slice k=beat computes a_reg[k*SLICE_W +: SLICE_W] + b_reg[same] + carry_reg.
  - The slice sum is written into sum[k*SLICE_W +: SLICE_W] and the slice carry-out into carry_reg; beat increments.
  - After the beat with beat==BEATS-1: cout=slice carry-out, go DONE.
- DONE:
  - out_valid=1. sum and cout are stable.
  - On out_ready, go IDLE.
- in_ready is high only in IDLE. in_valid is ignored in RUN and DONE.
- sum and cout hold their last value after the output handshake until overwritten by the next operation.
- beat counter width is clog2(BEATS), minimum 1 bit. There is no wrap-around beyond BEATS-1.
- Arithmetic is unsigned modulo 2^W; the carry out of bit W-1 goes to cout.

## Timing

- Reset values: in_ready=0 while rst is asserted, then 1 in IDLE; out_valid=0, sum=0, cout=0; internal registers 0.
- Accept at edge E0 → RUN during cycles E0..E_BEATS → out_valid rises after edge E_BEATS (latency BEATS cycles from accept edge).
- Result handshake at edge E_{BEATS+1} at the earliest → IDLE. The next accept is possible at E_{BEATS+2} at the earliest. Maximum throughput is one operation per BEATS+2 cycles.
- out_ready held low: the block stays in DONE indefinitely with outputs frozen.
- Asserting rst mid-RUN or mid-DONE aborts the operation immediately. No out_valid is produced for it and outputs return to their reset values.
- Operands changing after accept have no effect.

## Configuration

- Macro LCA_WIDE_ADD_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on accept.
  - The effective B is b_reg XOR {W{sub}} per slice, and the initial carry_reg is cin XOR sub. So sub=1,cin=0 gives a−b, and sub=1,cin=1 gives a−b−1.
  - cout=1 means no borrow.
- Undefined: no sub port, addition only.

## Test plan

- a=1, b=2^W−1, cin=0 → sum=0, cout=1. out_valid rises exactly 4 edges after the accept edge (defaults).
- a=2^64−1, b=1, cin=0 → the carry crosses from beat 0 to beat 1, giving sum=2^64, cout=0. With a=b=2^W−1, cin=1 → sum=2^W−1, cout=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_valid, sum and cout stay constant and in_ready=0. Raising out_ready → the cycle after the handshake has out_valid=0 and in_ready=1.
- Hold in_valid high with out_ready tied high for two operations (3+4, then 10+20) → results 7 then 30, accept edges spaced 6 cycles apart, in_valid ignored outside IDLE.
- Assert rst at beat 2 of an operation → out_valid=0, sum=0, cout=0 immediately. After release, in_ready=1 and no result from the aborted operation appears.
- With LCA_WIDE_ADD_SEQ_SUB_EN: a=5, b=7, sub=1, cin=0 → sum=2^W−2, cout=0. Then a=7, b=5, sub=1 → sum=2, cout=1.
